// File: rtl/fsm10_pkg.sv
// State encoding of the fsm10 pulse engine; the scheduler shadows the engine with this type.
package fsm10_pkg;
  typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8, S9} state_e;
endpackage

// File: rtl/fsm_sched_pkg.sv
// Controller states and constants shared by the scheduler and its arbiter.
package fsm_sched_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} ctl_state_e;
  localparam int REPLAY_LEN = 7;
endpackage

// File: rtl/fsm_sched_rr_arb.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IDX_W = $clog2(NREQ);

  logic                 found;
  logic [IDX_W-1:0]     k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IDX_W'((int'(ptr) + i) % NREQ);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/fsm_sched.sv
// Round-robin scheduler sharing one fsm10 engine; replays S3..S9 and checks y1 against a shadow.
module fsm_sched
  import fsm_sched_pkg::*;
  import fsm10_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int RPT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         short_req,
  input  logic [NREQ*RPT_W-1:0]   rpt,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    eng_go,
  output logic                    eng_jmp,
  input  logic                    eng_y1,
  input  logic                    err_clr,
  output logic                    err,
  output logic [$clog2(NREQ)-1:0] err_id
);
  localparam int IDX_W = $clog2(NREQ);

  ctl_state_e       ctl;
  state_e           shadow;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] g;
  logic [RPT_W-1:0] loops;
  logic             short_q;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             mismatch;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign mismatch = (ctl == RUN) && (eng_y1 != (shadow == S3));

  // eng_go/eng_jmp are registered: each transition loads the value the next state needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl     <= IDLE;
      shadow  <= S0;
      ptr     <= '0;
      g       <= '0;
      loops   <= '0;
      short_q <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      eng_go  <= 1'b0;
      eng_jmp <= 1'b0;
      err     <= 1'b0;
      err_id  <= '0;
    end else begin
      if (mismatch) begin
        err <= 1'b1;
        if (!err) err_id <= g;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (ctl)
        IDLE: begin
          if (|req) begin
            ctl     <= LAUNCH;
            g       <= arb_idx;
            gnt     <= arb_gnt;
            short_q <= short_req[arb_idx];
            loops   <= rpt[arb_idx*RPT_W +: RPT_W];
            busy    <= 1'b1;
            eng_go  <= 1'b1;
            eng_jmp <= short_req[arb_idx];
          end
        end
        LAUNCH: begin
          ctl     <= RUN;
          eng_go  <= 1'b0;
          eng_jmp <= 1'b0;
          shadow  <= short_q ? S3 : S1;
        end
        RUN: begin
          if (shadow == S9) begin
            eng_jmp <= 1'b0;
            if (loops != '0) begin
              loops  <= loops - 1'b1;
              shadow <= S3;
            end else begin
              ctl    <= DONE;
              shadow <= S0;
              done   <= gnt;
            end
          end else begin
            shadow  <= state_e'(shadow + 4'd1);
            eng_jmp <= (shadow == S8) && (loops != '0);
          end
        end
        DONE: begin
          ctl  <= IDLE;
          done <= '0;
          gnt  <= '0;
          busy <= 1'b0;
          ptr  <= (g == IDX_W'(NREQ - 1)) ? '0 : g + 1'b1;
        end
        default: ctl <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fsm_sched.md
# fsm_sched

Round-robin scheduler that shares one `fsm` pulse engine (package `fsm10_pkg`) among `NREQ` requesters. It grants one requester at a time and launches the engine with `go`/`jmp`. It replays the S3..S9 segment a per-request number of times and tracks the engine with a shadow state. It also checks every `y1` against the expected S3 position. The block sits directly in front of the engine; the engine's `go`, `jmp` and `y1` connect only to this block.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `RPT_W`, 2: width of the per-request replay count.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low; shared with the engine.
- `req`  in  NREQ: level request per requester.
- `short_req`  in  NREQ: 1 means enter at S3, skipping S1/S2.
- `rpt`  in  NREQ*RPT_W: extra S3..S9 passes; requester i uses bits [i*RPT_W +: RPT_W].
- `gnt`  out  NREQ: one-hot grant, held for the whole job.
- `done`  out  NREQ: one-cycle completion pulse for the granted requester.
- `busy`  out  1: high in any state other than IDLE.
- `eng_go`, `eng_jmp`  out  1: drive the engine's `go` and `jmp`.
- `eng_y1`  in  1: the engine's `y1`.
- `err_clr`  in  1: clears `err`.
- `err`  out  1: sticky flag; `y1` did not match the shadow state.
- `err_id`  out  $clog2(NREQ): index of the requester that was granted on the first error.

## Operation
Controller states:
- **IDLE.** If any `req` is high, `rr_arb` picks the winner, starting its search at pointer `ptr`. At the same edge the block latches the winner index, its `short_req` bit and its `rpt` value into `loops`. Next state is LAUNCH.
- **LAUNCH** (1 cycle). `eng_go`=1 and `eng_jmp`=latched short bit. The shadow state moves to S3 if short, otherwise S1. Next state is RUN.
- **RUN.** `eng_go`=0. The shadow follows the engine rules for the `jmp` this block drives. `eng_jmp`=1 only when shadow=S9 and `loops`≠0; in that cycle `loops` decrements and the shadow returns to S3. When shadow=S9 and `loops`=0, next state is DONE and the shadow becomes S0.
- **DONE** (1 cycle). `done[g]`=1. `ptr` becomes g+1, wrapping modulo `NREQ`. Next state is IDLE with `gnt` cleared.

Rules:
- `eng_go` and `eng_jmp` decode from registered state only, with no input-to-output paths. `eng_jmp` is 0 in S1, S2 and S4..S8.
- `gnt` is valid from LAUNCH through DONE. Dropping `req` mid-job does not abort the job.
- A `req` still high in IDLE after DONE is re-arbitrated at its normal round-robin priority.
- Check, in RUN only: if `eng_y1` ≠ (shadow==S3) and `err` is 0, then set `err` and load `err_id`=g. If the mismatch occurs in the same cycle as `err_clr`, set wins.
- Reset, including mid-job: controller returns to IDLE, shadow=S0, `ptr`=0, `loops`=0. All outputs are 0: `gnt`, `done`, `busy`, `eng_go`, `eng_jmp`, `err`, `err_id`. The engine resets on the same `rst_n`, so the two stay aligned.

## Timing
Request seen in IDLE at cycle 0. LAUNCH is cycle 1. Cycle counts below are for a non-short job.

- **Non-short, `rpt`=0:** shadow S1@2, S2@3, S3@4 (`y1`=1), S4..S9@5..10. DONE@11, IDLE@12.
- **Short, `rpt`=0:** S3@2, S9@8, DONE@9.
- **Each replay:** adds 7 cycles and one more `y1` pulse; a job produces `rpt`+1 `y1` pulses in total.
- **Back-to-back jobs:** the minimum gap is 1 IDLE cycle between a DONE and the next LAUNCH.

## Structure
- Package `fsm_sched_pkg` holds `ctl_state_e` (IDLE, LAUNCH, RUN, DONE) and the constant `REPLAY_LEN`=7.
- The shadow state reuses `fsm10_pkg::state_e`.
- One sub-module, `rr_arb`: combinational round-robin pick from `req` and `ptr`, producing a one-hot grant and an index.

## Test plan
- **Single job, S1 entry:** `req`[0]=1, `short_req`=0, `rpt`=0 → `gnt`=0001 @1..11; one `y1` @4; `done`[0] @11; `err`=0.
- **Short entry with replays:** `req`[2], `short_req`[2]=1, `rpt`=3 → `y1` @2,9,16,23; `eng_jmp` high @8,15,22; `done`[2] @30.
- **Round-robin fairness:** all 4 `req` held high → grant order 0,1,2,3,0; each job non-short, 11 cycles, with a 1-cycle IDLE gap.
- **Error detection:** bench forces `eng_y1`=1 at shadow S5 during requester 1's job → `err`=1, `err_id`=1. `err_clr` in a later cycle with no mismatch → `err`=0.
- **Reset mid-job:** `rst_n` low while shadow=S6 → all outputs 0 immediately, `ptr`=0. After release with `req`=1010, requester 1 is granted first.
- **Request withdrawal:** `req`[3] dropped at cycle 5 of its job → the job completes and `done`[3] still pulses at cycle 11.
